// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the parametrised sync FIFO
package fifo_pkg;

    localparam int FIFO_DEF_WIDTH     = 8;
    localparam int FIFO_DEF_DEPTH     = 8;
    localparam int FIFO_DEF_AF_THRESH = 6;
    localparam int FIFO_DEF_AE_THRESH = 1;

    // Address width for a given depth; pointers carry one extra wrap bit on top.
    function automatic int FIFO_ADDR_W(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit fifo_is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// rtl/param_sync_fifo_if.sv - FIFO handshake/status bundle
// Purpose: groups write, read, status and error signals of param_sync_fifo.
// master: producer/consumer side (drives wr_en, din, rd_en, clr_err).
// slave : FIFO side (drives dout, valid, full, empty, almost_*, count, overflow, underflow).
interface param_sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_DEF_WIDTH,
    parameter int DEPTH = FIFO_DEF_DEPTH
);
    localparam int AW = FIFO_ADDR_W(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, din, rd_en, clr_err,
        input  dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, clr_err,
        output dout, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - WIDTH x DEPTH storage, one sync write port, one async read port
// Ports: clk_i, we_i, waddr_i, wdata_i (write); raddr_i, rdata_o (combinational read).
// Storage is intentionally not reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_DEF_WIDTH,
    parameter int DEPTH = FIFO_DEF_DEPTH,
    localparam int AW   = FIFO_ADDR_W(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised single-clock FIFO with thresholds and sticky errors
// Ports: clk, rst_n (async assert, active low), bus (param_sync_fifo_if.slave).
// Build option FIFO_FWFT_EN: first-word-fall-through read; otherwise registered read, 1-cycle latency.
// Pointers, count, flags and the read-data register live here; storage is in fifo_mem.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_DEF_WIDTH,
    parameter int DEPTH     = FIFO_DEF_DEPTH,
    parameter int AF_THRESH = FIFO_DEF_AF_THRESH,
    parameter int AE_THRESH = FIFO_DEF_AE_THRESH
) (
    input logic               clk,
    input logic               rst_n,
    param_sync_fifo_if.slave  bus
);

    localparam int          AW      = FIFO_ADDR_W(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

    if (!fifo_is_pow2(DEPTH) || DEPTH < 2 || WIDTH < 1 ||
        !(AE_THRESH < AF_THRESH) || AF_THRESH > DEPTH || AE_THRESH < 0) begin : g_cfg_err
        $error("param_sync_fifo: illegal DEPTH/threshold configuration");
    end

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] count_q, count_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        af_q, af_d;
    logic        ae_q, ae_d;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;

    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] mem_rdata;

    // Acceptance is decided from the registered flags only, so a simultaneous
    // read never makes room for a write in the same cycle.
    assign wr_acc = bus.wr_en && !full_q;
    assign rd_acc = bus.rd_en && !empty_q;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (bus.din),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    // Wrap bits are kept for debug visibility; occupancy comes from count_q.
    logic unused_wrap_bits;
    assign unused_wrap_bits = wptr_q[AW] ^ rptr_q[AW];

    always_comb begin
        wptr_d  = wr_acc ? wptr_q + ONE_C : wptr_q;
        rptr_d  = rd_acc ? rptr_q + ONE_C : rptr_q;
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
        // A fresh error outranks a clear in the same cycle.
        if (bus.wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (bus.clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (bus.rd_en && empty_q) begin
            udf_d = 1'b1;
        end else if (bus.clr_err) begin
            udf_d = 1'b0;
        end else begin
            udf_d = udf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented directly; forced to zero while empty so stale
    // storage never leaks onto dout.
    assign bus.dout  = empty_q ? '0 : mem_rdata;
    assign bus.valid = !empty_q;
`else
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;

    always_comb begin
        dout_d  = rd_acc ? mem_rdata : dout_q;
        valid_d = rd_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - self-checking bench for param_sync_fifo (both read modes)
module tb_param_sync_fifo;

`ifdef FIFO_FWFT_EN
    localparam bit FW = 1'b1;
`else
    localparam bit FW = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    param_sync_fifo_if #(.WIDTH(8), .DEPTH(8)) bus ();

    param_sync_fifo #(
        .WIDTH     (8),
        .DEPTH     (8),
        .AF_THRESH (6),
        .AE_THRESH (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       rd;
        logic       clr;
        logic [3:0] cnt;
        logic       emp;
        logic       ful;
        logic       ae;
        logic       af;
        logic       ovf;
        logic       udf;
        logic       vld;
        logic [7:0] dout;
        logic       chk_dout;
    } vec_t;

    vec_t       vt [11];
    logic [7:0] sb [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [3:0] cnt, input logic emp, input logic ful,
                          input logic ae, input logic af, input logic ovf, input logic udf);
        chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(emp));
        chk({tag, ".full"}, 32'(bus.full), 32'(ful));
        chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
        chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(af));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(ovf));
        chk({tag, ".underflow"}, 32'(bus.underflow), 32'(udf));
    endtask

    task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
        bus.wr_en   = wr;
        bus.din     = d;
        bus.rd_en   = rd;
        bus.clr_err = clr;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    // Pop one word and compare it against the scoreboard head, accounting for
    // where each read mode presents the data.
    task automatic read_chk(input string tag, input logic wr, input logic [7:0] d);
        logic [7:0] exp;
        exp = sb.pop_front();
        if (FW) begin
            chk({tag, ".fwft_valid"}, 32'(bus.valid), 32'd1);
            chk({tag, ".fwft_dout"}, 32'(bus.dout), 32'(exp));
        end
        step(wr, d, 1'b1, 1'b0);
        if (!FW) begin
            chk({tag, ".valid"}, 32'(bus.valid), 32'd1);
            chk({tag, ".dout"}, 32'(bus.dout), 32'(exp));
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.din     = 8'h00;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;

        //            wr    din    rd    clr   cnt emp ful ae af ovf udf vld  dout                   chk
        vt[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1, 0, 1, 0, 0, 0, 1'b0, 8'h00,               1'b1};
        vt[1]  = '{1'b1, 8'h1C, 1'b0, 1'b0, 4'd1, 0, 0, 1, 0, 0, 0, FW,   FW ? 8'h1C : 8'h00,  1'b1};
        vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1, 0, 1, 0, 0, 0, !FW,  8'h1C,               !FW};
        vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1, 0, 1, 0, 0, 0, 1'b0, 8'h1C,               !FW};
        vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1, 0, 1, 0, 0, 1, 1'b0, 8'h1C,               !FW};
        vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1, 0, 1, 0, 0, 1, 1'b0, 8'h1C,               !FW};
        vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1, 0, 1, 0, 0, 0, 1'b0, 8'h1C,               !FW};
        vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1, 0, 1, 0, 0, 1, 1'b0, 8'h1C,               !FW};
        vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1, 0, 1, 0, 0, 0, 1'b0, 8'h1C,               !FW};
        vt[9]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 4'd1, 0, 0, 1, 0, 0, 1, FW,   FW ? 8'hA5 : 8'h1C,  1'b1};
        vt[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1, 0, 1, 0, 0, 0, !FW,  8'hA5,               !FW};

        // Reset values while rst_n is held low
        @(posedge clk);
        #1;
        chk_st("rst", 4'd0, 1, 0, 1, 0, 0, 0);
        chk("rst.valid", 32'(bus.valid), 32'd0);
        chk("rst.dout", 32'(bus.dout), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table: reset, single word, underflow / clear, empty + wr + rd
        for (int i = 0; i < 11; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(vt[i].wr, vt[i].din, vt[i].rd, vt[i].clr);
            chk_st(tag, vt[i].cnt, vt[i].emp, vt[i].ful, vt[i].ae, vt[i].af, vt[i].ovf, vt[i].udf);
            chk({tag, ".valid"}, 32'(bus.valid), 32'(vt[i].vld));
            if (vt[i].chk_dout) begin
                chk({tag, ".dout"}, 32'(bus.dout), 32'(vt[i].dout));
            end
        end

        // Fill to full, overflow on ninth write, drain in order
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 8'(k), 1'b0, 1'b0);
            sb.push_back(8'(k));
            chk_st($sformatf("fill%0d", k), 4'(k), 0, k == 8, k <= 1, k >= 6, 0, 0);
        end
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk_st("ovf", 4'd8, 0, 1, 0, 1, 1, 0);
        for (int k = 0; k < 8; k++) begin
            read_chk($sformatf("drain%0d", k), 1'b0, 8'h00);
        end
        chk_st("drained", 4'd0, 1, 0, 1, 0, 1, 0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(bus.overflow), 32'd0);

        // Steady-state streaming at count=3 across pointer wrap
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
            sb.push_back(8'(8'h10 + k));
        end
        for (int k = 0; k < 20; k++) begin
            sb.push_back(8'(8'h13 + k));
            read_chk($sformatf("wrap%0d", k), 1'b1, 8'(8'h13 + k));
            chk($sformatf("wrap%0d.count", k), 32'(bus.count), 32'd3);
        end
        for (int k = 0; k < 3; k++) begin
            read_chk($sformatf("wrapdrain%0d", k), 1'b0, 8'h00);
        end
        chk_st("wrapdone", 4'd0, 1, 0, 1, 0, 0, 0);

        // Full + wr + rd: head read, write dropped, overflow set
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
            sb.push_back(8'(8'h20 + k));
        end
        chk("full8", 32'(bus.full), 32'd1);
        read_chk("fullrw", 1'b1, 8'hEE);
        chk_st("fullrw", 4'd7, 0, 0, 0, 1, 1, 0);

        // Asynchronous reset mid-burst, away from the clock edge
        step(1'b1, 8'h30, 1'b0, 1'b0);
        bus.wr_en = 1'b1;
        bus.din   = 8'h31;
        #2;
        rst_n = 1'b0;
        #1;
        chk_st("midrst", 4'd0, 1, 0, 1, 0, 0, 0);
        chk("midrst.valid", 32'(bus.valid), 32'd0);
        chk("midrst.dout", 32'(bus.dout), 32'd0);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        rst_n     = 1'b1;
        sb.delete();
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk_st("postrst", 4'd0, 1, 0, 1, 0, 0, 0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        sb.push_back(8'h55);
        read_chk("postrst_rd", 1'b0, 8'h00);
        chk_st("postrst_end", 4'd0, 1, 0, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
